// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: ID-stage hazard and stall controller.
// Inserts a single bubble on load-use, flushes IF/ID for BR_FLUSH_CYCLES after a
// taken branch, and freezes the pipe while data memory is busy, aborting the wait
// after MEM_TIMEOUT cycles. Counts every cycle in which the PC is held.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   RUN      | normal flow; branch flush and load-use bubbles handled in place
//   FLUSH    | remaining post-branch flush cycles, counted down in flush_cnt
//   MEM_WAIT | pipe frozen on data memory; returns to ret_state when released
module hazard_stall_ctrl #(
    parameter int BR_FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT     = 15,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       id_rn,
    input  logic [3:0]       id_rm,
    input  logic [3:0]       id_rd,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             id_use_rd,
    input  logic [3:0]       ex_rd,
    input  logic             ex_load,
    input  logic             ex_rf,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             nop_sel,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

    state_t     state, state_nxt;
    state_t     ret_state, ret_nxt;
    logic [2:0] flush_cnt, flush_nxt;
    logic [7:0] wait_cnt, wait_nxt;
    logic       timeout_set;
    logic       lu;
    logic       mem_stall;

    // Load-use: EX load writes a register that the ID instruction actually reads.
    assign lu = ex_load & ex_rf &
                ((id_use_rn & (id_rn == ex_rd)) |
                 (id_use_rm & (id_rm == ex_rd)) |
                 (id_use_rd & (id_rd == ex_rd)));

    // An access completing in the same cycle it is requested never stalls.
    assign mem_stall = mem_req & ~mem_ready;

    // Same-cycle hazard response and next-state selection.
    always_comb begin
        nop_sel     = 1'b0;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        pipe_freeze = 1'b0;
        state_nxt   = state;
        ret_nxt     = ret_state;
        flush_nxt   = flush_cnt;
        wait_nxt    = wait_cnt;
        timeout_set = 1'b0;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    pipe_freeze = 1'b1;
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    state_nxt   = MEM_WAIT;
                    ret_nxt     = RUN;
                    wait_nxt    = 8'd1;
                end else if (br_taken) begin
                    // Branch beats load-use: the ID instruction is squashed anyway.
                    ifid_flush = 1'b1;
                    nop_sel    = 1'b1;
                    if (BR_FLUSH_CYCLES > 1) begin
                        state_nxt = FLUSH;
                        flush_nxt = 3'(BR_FLUSH_CYCLES - 1);
                    end
                end else if (lu) begin
                    nop_sel = 1'b1;
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                end
            end
            FLUSH: begin
                if (mem_stall) begin
                    // flush_cnt is held so the flush resumes after the wait.
                    pipe_freeze = 1'b1;
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    state_nxt   = MEM_WAIT;
                    ret_nxt     = FLUSH;
                    wait_nxt    = 8'd1;
                end else begin
                    ifid_flush = 1'b1;
                    nop_sel    = 1'b1;
                    if (flush_cnt <= 3'd1) begin
                        state_nxt = RUN;
                        flush_nxt = 3'd0;
                    end else begin
                        flush_nxt = flush_cnt - 3'd1;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt = ret_state;
                    wait_nxt  = 8'd0;
                end else if (wait_cnt == 8'(MEM_TIMEOUT)) begin
                    timeout_set = 1'b1;
                    state_nxt   = ret_state;
                    wait_nxt    = 8'd0;
                end else begin
                    pipe_freeze = 1'b1;
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    wait_nxt    = wait_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
        if (reset) begin
            nop_sel     = 1'b1;
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            pipe_freeze = 1'b0;
        end
    end

    // State, counters and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            ret_state   <= RUN;
            flush_cnt   <= 3'd0;
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            flush_cnt <= flush_nxt;
            wait_cnt  <= wait_nxt;
            if (timeout_set) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    // Saturating count of cycles with the PC held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (!pc_en && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed scenarios plus randomized traffic against a
// cycle-level reference model of the stall/flush rules.
module tb_hazard_stall_ctrl;

    localparam int BR    = 3;
    localparam int MTO   = 15;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    // Packed output vector: {nop_sel, pc_en, ifid_en, ifid_flush, pipe_freeze}
    localparam logic [4:0] O_RUN = 5'b01100;
    localparam logic [4:0] O_FRZ = 5'b00001;
    localparam logic [4:0] O_FLS = 5'b11110;
    localparam logic [4:0] O_BUB = 5'b10000;
    localparam logic [4:0] O_RST = 5'b10010;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    id_rn, id_rm, id_rd, ex_rd;
    logic          id_use_rn, id_use_rm, id_use_rd;
    logic          ex_load, ex_rf, br_taken, mem_req, mem_ready;
    logic          nop_sel, pc_en, ifid_en, ifid_flush, pipe_freeze, mem_timeout;
    logic [CW-1:0] stall_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit m_in_wait;
    int m_k;
    int m_pend;
    bit m_to;
    int m_cnt;
    logic [4:0] obs_o;

    hazard_stall_ctrl #(.BR_FLUSH_CYCLES(BR), .MEM_TIMEOUT(MTO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
        .ex_rd(ex_rd), .ex_load(ex_load), .ex_rf(ex_rf),
        .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .nop_sel(nop_sel), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        id_rn = 4'd0; id_rm = 4'd0; id_rd = 4'd0; ex_rd = 4'd0;
        id_use_rn = 1'b0; id_use_rm = 1'b0; id_use_rd = 1'b0;
        ex_load = 1'b0; ex_rf = 1'b0; br_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // One clock: sample at negedge, compare to model, advance model, return at posedge+1.
    task automatic run_cycle();
        logic [4:0] exp_o;
        bit         lu;
        @(negedge clk);
        obs_o = {nop_sel, pc_en, ifid_en, ifid_flush, pipe_freeze};
        if (reset) begin
            check_val("rst_outs", 32'(obs_o), 32'(O_RST));
            check_val("rst_timeout", 32'(mem_timeout), 32'd0);
            check_val("rst_count", 32'(stall_count), 32'd0);
            m_in_wait = 0; m_k = 0; m_pend = 0; m_to = 0; m_cnt = 0;
        end else begin
            lu = ex_load && ex_rf && ((id_use_rn && id_rn == ex_rd) ||
                                      (id_use_rm && id_rm == ex_rd) ||
                                      (id_use_rd && id_rd == ex_rd));
            check_val("timeout", 32'(mem_timeout), 32'(m_to));
            check_val("count", 32'(stall_count), 32'(m_cnt));
            if (m_in_wait) begin
                if (mem_ready) begin
                    exp_o = O_RUN; m_in_wait = 0;
                end else if (m_k == MTO + 1) begin
                    exp_o = O_RUN; m_in_wait = 0; m_to = 1;
                end else begin
                    exp_o = O_FRZ; m_k++;
                end
            end else if (mem_req && !mem_ready) begin
                exp_o = O_FRZ; m_in_wait = 1; m_k = 2;
            end else if (m_pend > 0) begin
                exp_o = O_FLS; m_pend--;
            end else if (br_taken) begin
                exp_o = O_FLS; m_pend = BR - 1;
            end else if (lu) begin
                exp_o = O_BUB;
            end else begin
                exp_o = O_RUN;
            end
            check_val("outs", 32'(obs_o), 32'(exp_o));
            if (exp_o[3] == 1'b0 && m_cnt < CMAX) m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu(input logic [3:0] r);
        ex_load = 1'b1; ex_rf = 1'b1; ex_rd = r; id_rn = r; id_use_rn = 1'b1;
    endtask

    initial begin
        int n;
        int c0;
        idle();
        reset = 1'b1;
        #2;
        repeat (3) run_cycle();
        reset = 1'b0;
        run_cycle();
        check_val("run_default", 32'(obs_o), 32'(O_RUN));

        // Load-use bubble, single cycle
        set_lu(4'd3);
        run_cycle();
        check_val("lu_bubble", 32'(obs_o), 32'(O_BUB));
        idle();
        check_val("lu_count", 32'(stall_count), 32'd1);
        run_cycle();

        // Non-reading field and non-writing EX give no stall
        set_lu(4'd3); id_use_rn = 1'b0;
        run_cycle();
        check_val("no_use", 32'(obs_o), 32'(O_RUN));
        set_lu(4'd3); ex_rf = 1'b0;
        run_cycle();
        check_val("no_rf", 32'(obs_o), 32'(O_RUN));
        idle(); ex_load = 1'b1; ex_rf = 1'b1; ex_rd = 4'd15; id_rd = 4'd15; id_use_rd = 1'b1;
        run_cycle();
        check_val("lu_rd15", 32'(obs_o), 32'(O_BUB));
        idle();

        // Taken branch: flush for BR cycles
        br_taken = 1'b1;
        n = 0;
        for (int i = 0; i < BR + 2; i++) begin
            run_cycle();
            br_taken = 1'b0;
            if (obs_o[1]) n++;
        end
        check_val("br_flush_len", 32'(n), 32'(BR));

        // Branch and load-use in the same cycle: branch wins
        set_lu(4'd5); br_taken = 1'b1;
        run_cycle();
        check_val("br_lu", 32'(obs_o), 32'(O_FLS));
        idle();
        repeat (BR) run_cycle();

        // Memory wait of 4 cycles, then ready
        c0 = int'(stall_count);
        mem_req = 1'b1; mem_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            if (obs_o[0]) n++;
        end
        mem_ready = 1'b1;
        run_cycle();
        check_val("mw_release", 32'(obs_o), 32'(O_RUN));
        idle();
        check_val("mw_freeze_len", 32'(n), 32'd4);
        check_val("mw_count", 32'(int'(stall_count) - c0), 32'd4);

        // Memory never ready: timeout after MTO freeze cycles, sticky
        mem_req = 1'b1; mem_ready = 1'b0;
        n = 0;
        for (int i = 0; i < MTO + 1; i++) begin
            run_cycle();
            if (obs_o[0]) n++;
        end
        check_val("to_freeze_len", 32'(n), 32'(MTO));
        check_val("to_flag", 32'(mem_timeout), 32'd1);
        idle();
        repeat (5) run_cycle();
        check_val("to_sticky", 32'(mem_timeout), 32'd1);

        // Randomized traffic with occasional mid-run reset
        for (int i = 0; i < 4000; i++) begin
            id_rn = 4'($urandom_range(0, 3)); id_rm = 4'($urandom_range(0, 3));
            id_rd = 4'($urandom_range(0, 3)); ex_rd = 4'($urandom_range(0, 3));
            id_use_rn = 1'($urandom); id_use_rm = 1'($urandom); id_use_rd = 1'($urandom);
            ex_load = 1'($urandom); ex_rf = 1'($urandom);
            br_taken = ($urandom_range(0, 7) == 0);
            mem_req = ($urandom_range(0, 3) == 0) || ((i / 500) % 2 == 1 && $urandom_range(0, 1) == 0);
            mem_ready = ((i / 250) % 2 == 1) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 299) == 0);
            run_cycle();
        end
        reset = 1'b0;
        idle();
        run_cycle();

        // Continuous load-use stall saturates the counter
        set_lu(4'd7);
        repeat (CMAX + 20) run_cycle();
        check_val("sat_count", 32'(stall_count), 32'(CMAX));
        idle();

        // Final reset clears everything
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        run_cycle();
        check_val("final_timeout", 32'(mem_timeout), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
